// File: rtl/pixel_fetch.sv
// pixel_fetch: turns display timing (de/hs/vs) into frame-RAM reads and an
// aligned RGB pixel stream. A window of IMG_W x IMG_H pixels starting at
// (X0, Y0) is read from RAM with a running address counter; everything else
// shows BORDER. Output latency is fixed at 3 clocks for pixel data and syncs.
//
// Optional feature: define PIXEL_FETCH_PALETTE_EN to treat mem_q as RGB332
// and expand it by bit replication; otherwise mem_q is shown as grayscale.
//
// Timing generator handshake: de/hs/vs carry no valid/ready handshake; every
// clock is one pixel slot, and the RAM answers each address exactly one clock
// after it is presented on mem_addr.
module pixel_fetch #(
  parameter int          IMG_W  = 400,
  parameter int          IMG_H  = 400,
  parameter int          X0     = 0,
  parameter int          Y0     = 0,
  parameter logic [23:0] BORDER = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de,
  input  logic        hs,
  input  logic        vs,
  input  logic [7:0]  mem_q,
  output logic [17:0] mem_addr,
  output logic [23:0] pix_rgb,
  output logic        pix_de,
  output logic        pix_hs,
  output logic        pix_vs,
  output logic        frame_err
);

  localparam logic [31:0] X_LO     = 32'(X0);
  localparam logic [31:0] X_HI     = 32'(X0 + IMG_W);
  localparam logic [31:0] Y_LO     = 32'(Y0);
  localparam logic [31:0] Y_HI     = 32'(Y0 + IMG_H);
  localparam logic [17:0] ADDR_MAX = 18'(IMG_W * IMG_H - 1);

  typedef enum logic {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] x;
  logic [31:0] y;
  logic [17:0] cnt;       // address of the next in-window pixel
  logic        full;      // last window address has been issued this frame
  logic        de_d;
  logic        vs_d;

  // Stage 1 travels with mem_addr, stage 2 with the RAM read in flight.
  logic        de1, hs1, vs1, win1;
  logic        de2, hs2, vs2, win2;

  logic        vs_rise;
  logic        de_fall;
  logic        in_win;
  logic [31:0] lines_seen;
  logic        short_frame;
  logic [23:0] rgb_from_q;

  // Edge detection, window test and end-of-frame completeness check.
  always_comb begin
    vs_rise     = vs & ~vs_d;
    de_fall     = de_d & ~de;
    in_win      = (state == RUN) && de &&
                  (x >= X_LO) && (x < X_HI) &&
                  (y >= Y_LO) && (y < Y_HI);
    // A line that has started (de now or pixels already counted) counts as seen.
    lines_seen  = y + (((x != 32'd0) || de) ? 32'd1 : 32'd0);
    short_frame = !full && (lines_seen >= Y_HI);
  end

  // Pixel byte to colour conversion.
  always_comb begin
`ifdef PIXEL_FETCH_PALETTE_EN
    rgb_from_q = {mem_q[7:5], mem_q[7:5], mem_q[7:6],
                  mem_q[4:2], mem_q[4:2], mem_q[4:3],
                  mem_q[1:0], mem_q[1:0], mem_q[1:0], mem_q[1:0]};
`else
    rgb_from_q = {mem_q, mem_q, mem_q};
`endif
  end

  // Frame FSM with position counters, address counter and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC_WAIT;
      x         <= '0;
      y         <= '0;
      cnt       <= '0;
      full      <= 1'b0;
      mem_addr  <= '0;
      frame_err <= 1'b0;
    end else if (vs_rise) begin
      // vs wins over a coincident de falling edge: everything restarts at 0.
      if (state == RUN && short_frame) frame_err <= 1'b1;
      state    <= RUN;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      full     <= 1'b0;
      mem_addr <= '0;
    end else if (state == RUN) begin
      if (de_fall) begin
        x <= '0;
        y <= y + 32'd1;
      end else if (de) begin
        x <= x + 32'd1;
      end
      mem_addr <= cnt;
      if (in_win) begin
        // Saturate at the last window address; never wrap within a frame.
        if (cnt == ADDR_MAX) full <= 1'b1;
        else                 cnt  <= cnt + 18'd1;
      end
    end
  end

  // Sync history and the two flag stages that track the RAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_d <= 1'b0;
      vs_d <= 1'b0;
      de1  <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      win1 <= 1'b0;
      de2  <= 1'b0;
      hs2  <= 1'b0;
      vs2  <= 1'b0;
      win2 <= 1'b0;
    end else begin
      de_d <= de;
      vs_d <= vs;
      de1  <= de;
      hs1  <= hs;
      vs1  <= vs;
      win1 <= in_win;
      de2  <= de1;
      hs2  <= hs1;
      vs2  <= vs1;
      win2 <= win1;
    end
  end

  // Output register: RAM colour inside the window, BORDER elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_rgb <= BORDER;
      pix_de  <= 1'b0;
      pix_hs  <= 1'b0;
      pix_vs  <= 1'b0;
    end else begin
      pix_rgb <= win2 ? rgb_from_q : BORDER;
      pix_de  <= de2;
      pix_hs  <= hs2;
      pix_vs  <= vs2;
    end
  end

endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 The block SHALL have parameter IMG_W, default 400, meaning image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 400, meaning image height in lines.
REQ-003 The block SHALL have parameter X0, default 0, meaning first active column of the image window.
REQ-004 The block SHALL have parameter Y0, default 0, meaning first active line of the image window.
REQ-005 The block SHALL have parameter BORDER, default 24'h000000, meaning RGB output outside the window.
REQ-006 Port clk SHALL be a 1-bit input: the single pixel clock; all state is on its rising edge.
REQ-007 Port rst SHALL be a 1-bit input: asynchronous, active-high reset.
REQ-008 Ports de, hs and vs SHALL be 1-bit inputs: active-high display-enable and syncs from the timing generator.
REQ-009 Port mem_q SHALL be an 8-bit input: pixel byte from a synchronous frame RAM with 1-cycle read latency.
REQ-010 Port mem_addr SHALL be an 18-bit output: registered frame-RAM read address.
REQ-011 Port pix_rgb SHALL be a 24-bit output: registered pixel colour, ordered R[23:16], G[15:8], B[7:0].
REQ-012 Ports pix_de, pix_hs and pix_vs SHALL be 1-bit outputs: de, hs and vs delayed to align with pix_rgb.
REQ-013 Port frame_err SHALL be a 1-bit output: sticky flag for a malformed frame.

Function
REQ-014 States SHALL be SYNC_WAIT and RUN; SYNC_WAIT → RUN on the first vs rising edge; RUN SHALL NOT leave except on reset.
REQ-015 In SYNC_WAIT, pix_rgb SHALL be BORDER and mem_addr SHALL hold 0; pix_de/hs/vs SHALL still be delayed copies of the inputs.
REQ-016 Column counter x SHALL increment on each cycle with de=1 and clear on the de falling edge.
REQ-017 Line counter y SHALL increment on each de falling edge and clear on the vs rising edge.
REQ-018 Window SHALL be X0 ≤ x < X0+IMG_W and Y0 ≤ y < Y0+IMG_H, evaluated only while de=1.
REQ-019 Address SHALL be a running counter, with no multiplier: +1 per in-window pixel, cleared on the vs rising edge.
REQ-020 The address SHALL saturate at IMG_W*IMG_H-1 and never wrap within a frame.
REQ-021 For an input pixel sampled in cycle n: mem_addr SHALL be valid in n+1, mem_q consumed in n+2, pix_* registered in n+3; fixed latency 3.
REQ-022 An in_window flag SHALL be pipelined alongside; out-of-window or de=0 pixels SHALL output BORDER.
REQ-023 A vs rising edge mid-line SHALL clear x, y and the address in the same cycle; the in-flight pipeline SHALL drain unaltered.
REQ-024 When a de falling edge and a vs rising edge occur in the same cycle, vs SHALL win and y SHALL equal 0.
REQ-025 frame_err SHALL set when, in RUN, a frame ends (vs rising edge) with fewer than IMG_W*IMG_H addresses issued while Y0+IMG_H ≤ line count.
REQ-026 frame_err SHALL stay set until reset.

Reset
REQ-027 Reset SHALL force SYNC_WAIT, x=y=0, mem_addr=0, pix_rgb=BORDER, pix_de=pix_hs=pix_vs=0, frame_err=0, and clear all pipeline flags.
REQ-028 Reset asserted mid-frame SHALL take effect immediately; after release, output SHALL stay BORDER until the next vs rising edge.

Configuration
REQ-029 Macro PIXEL_FETCH_PALETTE_EN defined: mem_q SHALL be RGB332 and expand to 24 bits by bit replication (R={q[7:5],q[7:5],q[7:6]}, G likewise, B={q[1:0]×4}).
REQ-030 Macro PIXEL_FETCH_PALETTE_EN undefined: pix_rgb SHALL be {mem_q,mem_q,mem_q} (grayscale).

Verification
REQ-031 Reset, then de pulses without vs -> pix_rgb=BORDER throughout, mem_addr=0.
REQ-032 vs edge, then line 0 with de high 800 cycles, IMG_W=400, X0=0 -> mem_addr 0..399 then held at 400; pix_de rises exactly 3 cycles after de.
REQ-033 RAM model returns addr[7:0]; mem_q=8'hE0 at window pixel 0 -> palette off: 24'hE0E0E0; PIXEL_FETCH_PALETTE_EN defined: 24'hFF0000.
REQ-034 Full 400x400 frame -> last address 159999, held at saturation; next vs rising edge -> 0; frame_err=0.
REQ-035 vs raised mid-line at x=123 -> x, y and address are 0 next cycle; the next frame's first pixel reads address 0; frame_err=1.
REQ-036 rst pulsed at line 200 -> all outputs take reset values asynchronously; BORDER until the following vs rising edge.
